light_safety_monitor: RTL and testbench

- Downstream conflict monitor between Traffic_Light_Controller and the lamp drivers.
- Consumes the four 3-bit light vectors (M1, M2, MT, S) and checks encoding, conflicts, transition order and minimum yellow time.
- Passes lights through registered while healthy.
- On any violation, latches a fault and forces all roads to flashing red until an operator clear is accepted.

---
 rtl/light_safety_monitor_if.sv | 28 ++
 rtl/light_safety_monitor.sv | 271 +++++++++++++++++++++++++++
 tb/tb_light_safety_monitor.sv | 390 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/light_safety_monitor_if.sv
// Signal bundle between the traffic light controller, the safety monitor
// and the lamp drivers. The controller side (master) drives the raw light
// vectors and the operator clear; the monitor side (slave) drives the lamp
// vectors and the fault status.
interface light_safety_monitor_if;
    logic [2:0] light_M1;
    logic [2:0] light_M2;
    logic [2:0] light_MT;
    logic [2:0] light_S;
    logic       fault_clr;
    logic [2:0] safe_M1;
    logic [2:0] safe_M2;
    logic [2:0] safe_MT;
    logic [2:0] safe_S;
    logic       fault;
    logic [2:0] fault_code;
    logic [1:0] fault_road;

    modport master (
        output light_M1, light_M2, light_MT, light_S, fault_clr,
        input  safe_M1, safe_M2, safe_MT, safe_S, fault, fault_code, fault_road
    );

    modport slave (
        input  light_M1, light_M2, light_MT, light_S, fault_clr,
        output safe_M1, safe_M2, safe_MT, safe_S, fault, fault_code, fault_road
    );
endinterface

// File: rtl/light_safety_monitor.sv
// Safety monitor sitting between the traffic light controller and the lamp
// drivers. While the controller behaves, its light vectors are passed to the
// lamps with one cycle of latency. The monitor checks each vector for a legal
// one-hot encoding, for conflicting green/yellow roads, for legal colour
// transitions and for a minimum yellow time. The first violation is latched
// and all lamps go to flashing red until an operator clear is accepted with
// every controller output red, followed by a short all-red recovery hold.
//
// Light encoding: bit2 = red, bit1 = yellow, bit0 = green.
// Road indices: M1 = 0, M2 = 1, MT = 2, S = 3.
// Fault codes: 1 bad encoding, 2 conflict, 3 illegal transition, 4 short yellow.
module light_safety_monitor #(
    parameter int MIN_YELLOW  = 3,
    parameter int FLASH_HALF  = 1,
    parameter int RECOVER_CYC = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    light_safety_monitor_if.slave  bus
);

    typedef enum logic [1:0] {
        RUN,
        FAULT,
        RECOVER
    } state_t;

    localparam logic [2:0] LT_RED = 3'b100;
    localparam logic [2:0] LT_YEL = 3'b010;
    localparam logic [2:0] LT_GRN = 3'b001;
    localparam logic [2:0] LT_OFF = 3'b000;

    localparam int YW = $clog2(MIN_YELLOW + 1);
    localparam int FW = $clog2(2 * FLASH_HALF);
    localparam int RW = $clog2(RECOVER_CYC + 1);

    localparam logic [YW-1:0] YEL_MAX    = YW'(MIN_YELLOW);
    localparam logic [FW-1:0] FLASH_LAST = FW'(2 * FLASH_HALF - 1);
    localparam logic [FW-1:0] FLASH_HALF_V = FW'(FLASH_HALF);
    localparam logic [RW-1:0] REC_LAST   = RW'(RECOVER_CYC);

    localparam logic [2:0] CODE_ENC   = 3'd1;
    localparam logic [2:0] CODE_CONF  = 3'd2;
    localparam logic [2:0] CODE_TRANS = 3'd3;
    localparam logic [2:0] CODE_SHORT = 3'd4;

    state_t        state_q, state_n;
    logic [2:0]    safe_q [4];
    logic [2:0]    safe_n [4];
    logic [2:0]    prev_q [4];
    logic [2:0]    prev_n [4];
    logic [YW-1:0] ycnt_q [4];
    logic [YW-1:0] ycnt_n [4];
    logic [FW-1:0] flash_q, flash_n;
    logic [RW-1:0] rec_q, rec_n;
    logic [2:0]    code_q, code_n;
    logic [1:0]    road_q, road_n;

    logic [2:0]    cur [4];
    logic [3:0]    bad_enc;
    logic [3:0]    bad_trans;
    logic [3:0]    short_yel;
    logic [3:0]    non_red;
    logic          all_red;
    logic          conflict_mt_m2;
    logic          conflict_s;
    logic          viol;
    logic [2:0]    viol_code;
    logic [1:0]    viol_road;

    assign cur[0] = bus.light_M1;
    assign cur[1] = bus.light_M2;
    assign cur[2] = bus.light_MT;
    assign cur[3] = bus.light_S;

    // A road is "active" (may move traffic) when it shows green or yellow.
    function automatic logic is_active(input logic [2:0] v);
        return (v == LT_YEL) || (v == LT_GRN);
    endfunction

    // Only R->R, R->G, G->G, G->Y, Y->Y and Y->R are allowed.
    function automatic logic legal_move(input logic [2:0] p, input logic [2:0] c);
        logic ok;
        ok = 1'b0;
        case (p)
            LT_RED:  ok = (c == LT_RED) || (c == LT_GRN);
            LT_GRN:  ok = (c == LT_GRN) || (c == LT_YEL);
            LT_YEL:  ok = (c == LT_YEL) || (c == LT_RED);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Lowest set road index in a per-road flag vector.
    function automatic logic [1:0] lowest_road(input logic [3:0] f);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (f[i]) begin
                r = 2'(i);
            end
        end
        return r;
    endfunction

    // Evaluate every check on the current inputs and pick the winning violation.
    always_comb begin
        bad_enc   = '0;
        bad_trans = '0;
        short_yel = '0;
        non_red   = '0;
        for (int i = 0; i < 4; i++) begin
            bad_enc[i]   = !((cur[i] == LT_RED) || (cur[i] == LT_YEL) || (cur[i] == LT_GRN));
            bad_trans[i] = !legal_move(prev_q[i], cur[i]);
            short_yel[i] = (prev_q[i] == LT_YEL) && (cur[i] == LT_RED) && (ycnt_q[i] < YEL_MAX);
            non_red[i]   = (cur[i] != LT_RED);
        end
        all_red        = ~|non_red;
        conflict_mt_m2 = is_active(cur[2]) && is_active(cur[1]);
        conflict_s     = is_active(cur[3]) &&
                         (is_active(cur[0]) || is_active(cur[1]) || is_active(cur[2]));

        viol      = 1'b0;
        viol_code = 3'd0;
        viol_road = 2'd0;
        if (|bad_enc) begin
            viol      = 1'b1;
            viol_code = CODE_ENC;
            viol_road = lowest_road(bad_enc);
        end else if (conflict_mt_m2) begin
            viol      = 1'b1;
            viol_code = CODE_CONF;
            viol_road = 2'd2;
        end else if (conflict_s) begin
            viol      = 1'b1;
            viol_code = CODE_CONF;
            viol_road = 2'd3;
        end else if (|bad_trans) begin
            viol      = 1'b1;
            viol_code = CODE_TRANS;
            viol_road = lowest_road(bad_trans);
        end else if (|short_yel) begin
            viol      = 1'b1;
            viol_code = CODE_SHORT;
            viol_road = lowest_road(short_yel);
        end
    end

    // Next-state and next-register values for the RUN/FAULT/RECOVER machine.
    always_comb begin
        state_n = state_q;
        safe_n  = safe_q;
        prev_n  = prev_q;
        ycnt_n  = ycnt_q;
        flash_n = flash_q;
        rec_n   = rec_q;
        code_n  = code_q;
        road_n  = road_q;

        case (state_q)
            RUN: begin
                if (viol) begin
                    state_n = FAULT;
                    code_n  = viol_code;
                    road_n  = viol_road;
                    flash_n = '0;
                    for (int i = 0; i < 4; i++) begin
                        safe_n[i] = LT_RED;
                    end
                end else begin
                    for (int i = 0; i < 4; i++) begin
                        safe_n[i] = cur[i];
                        prev_n[i] = cur[i];
                        if (cur[i] == LT_YEL) begin
                            ycnt_n[i] = (ycnt_q[i] == YEL_MAX) ? YEL_MAX : ycnt_q[i] + YW'(1);
                        end else begin
                            ycnt_n[i] = '0;
                        end
                    end
                end
            end

            FAULT: begin
                if (bus.fault_clr && all_red) begin
                    state_n = RECOVER;
                    rec_n   = '0;
                    for (int i = 0; i < 4; i++) begin
                        safe_n[i] = LT_RED;
                    end
                end else begin
                    flash_n = (flash_q == FLASH_LAST) ? '0 : flash_q + FW'(1);
                    for (int i = 0; i < 4; i++) begin
                        safe_n[i] = (flash_n < FLASH_HALF_V) ? LT_RED : LT_OFF;
                    end
                end
            end

            RECOVER: begin
                for (int i = 0; i < 4; i++) begin
                    safe_n[i] = LT_RED;
                end
                if (all_red) begin
                    if (rec_q + RW'(1) == REC_LAST) begin
                        state_n = RUN;
                        code_n  = 3'd0;
                        road_n  = 2'd0;
                        rec_n   = '0;
                        for (int i = 0; i < 4; i++) begin
                            prev_n[i] = LT_RED;
                            ycnt_n[i] = '0;
                        end
                    end else begin
                        rec_n = rec_q + RW'(1);
                    end
                end else begin
                    state_n = FAULT;
                    code_n  = CODE_TRANS;
                    road_n  = lowest_road(non_red);
                    flash_n = '0;
                end
            end

            default: begin
                state_n = RUN;
            end
        endcase
    end

    // State register; reset always lands in RUN.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_n;
        end
    end

    // Lamp, history, counter and fault-record registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                safe_q[i] <= LT_RED;
                prev_q[i] <= LT_RED;
                ycnt_q[i] <= '0;
            end
            flash_q <= '0;
            rec_q   <= '0;
            code_q  <= 3'd0;
            road_q  <= 2'd0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                safe_q[i] <= safe_n[i];
                prev_q[i] <= prev_n[i];
                ycnt_q[i] <= ycnt_n[i];
            end
            flash_q <= flash_n;
            rec_q   <= rec_n;
            code_q  <= code_n;
            road_q  <= road_n;
        end
    end

    assign bus.safe_M1    = safe_q[0];
    assign bus.safe_M2    = safe_q[1];
    assign bus.safe_MT    = safe_q[2];
    assign bus.safe_S     = safe_q[3];
    assign bus.fault      = (state_q != RUN);
    assign bus.fault_code = code_q;
    assign bus.fault_road = road_q;

endmodule

// File: tb/tb_light_safety_monitor.sv
// Testbench for light_safety_monitor. A rule-level model of the monitor
// (mode, per-road history, fault age) predicts the lamp vectors and fault
// status after every clock edge; directed scenarios and a randomized run are
// compared against it, with a few scenario-specific expected constants.
module tb_light_safety_monitor;

    localparam int MIN_YELLOW  = 3;
    localparam int FLASH_HALF  = 1;
    localparam int RECOVER_CYC = 2;

    localparam int R = 4;
    localparam int Y = 2;
    localparam int G = 1;

    logic clk = 1'b0;
    logic rst = 1'b0;

    light_safety_monitor_if bus_if ();

    light_safety_monitor #(
        .MIN_YELLOW (MIN_YELLOW),
        .FLASH_HALF (FLASH_HALF),
        .RECOVER_CYC(RECOVER_CYC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cycle  = 0;

    int drv [4];
    bit drv_clr;

    // Reference model: 0 = running, 1 = fault flashing, 2 = recovering
    int m_mode;
    int m_prev [4];
    int m_yel  [4];
    int m_safe [4];
    int m_since;
    int m_rec;
    int m_code;
    int m_road;

    function automatic bit act(input int v);
        return (v == G) || (v == Y);
    endfunction

    function automatic bit legal(input int p, input int c);
        return (p == R && (c == R || c == G)) ||
               (p == G && (c == G || c == Y)) ||
               (p == Y && (c == Y || c == R));
    endfunction

    task model_reset();
        m_mode  = 0;
        m_since = 0;
        m_rec   = 0;
        m_code  = 0;
        m_road  = 0;
        for (int r = 0; r < 4; r++) begin
            m_prev[r] = R;
            m_yel[r]  = 0;
            m_safe[r] = R;
        end
    endtask

    // Advance the model by one clock edge using the values currently driven.
    task model_edge();
        int best;
        int key;
        bit all_red;
        all_red = 1'b1;
        for (int r = 0; r < 4; r++) if (drv[r] != R) all_red = 1'b0;
        if (m_mode == 0) begin
            best = 99;
            for (int r = 0; r < 4; r++) begin
                key = 99;
                if (!(drv[r] == R || drv[r] == Y || drv[r] == G)) key = 1 * 4 + r;
                else if (!legal(m_prev[r], drv[r])) key = 3 * 4 + r;
                else if (m_prev[r] == Y && drv[r] == R && m_yel[r] < MIN_YELLOW) key = 4 * 4 + r;
                if (key < best) best = key;
            end
            if (act(drv[3]) && (act(drv[0]) || act(drv[1]) || act(drv[2])) && (2 * 4 + 3) < best)
                best = 2 * 4 + 3;
            if (act(drv[2]) && act(drv[1]) && (2 * 4 + 2) < best)
                best = 2 * 4 + 2;
            if (best < 99) begin
                m_mode  = 1;
                m_code  = best / 4;
                m_road  = best % 4;
                m_since = 0;
                for (int r = 0; r < 4; r++) m_safe[r] = R;
            end else begin
                for (int r = 0; r < 4; r++) begin
                    m_safe[r] = drv[r];
                    m_yel[r]  = (drv[r] == Y) ? ((m_yel[r] + 1 > MIN_YELLOW) ? MIN_YELLOW : m_yel[r] + 1) : 0;
                    m_prev[r] = drv[r];
                end
            end
        end else if (m_mode == 1) begin
            if (drv_clr && all_red) begin
                m_mode = 2;
                m_rec  = 0;
                for (int r = 0; r < 4; r++) m_safe[r] = R;
            end else begin
                m_since++;
                for (int r = 0; r < 4; r++) m_safe[r] = (((m_since / FLASH_HALF) % 2) == 1) ? 0 : R;
            end
        end else begin
            for (int r = 0; r < 4; r++) m_safe[r] = R;
            if (all_red) begin
                m_rec++;
                if (m_rec >= RECOVER_CYC) begin
                    m_mode = 0;
                    m_code = 0;
                    m_road = 0;
                    for (int r = 0; r < 4; r++) begin
                        m_prev[r] = R;
                        m_yel[r]  = 0;
                    end
                end
            end else begin
                m_mode  = 1;
                m_code  = 3;
                m_since = 0;
                for (int r = 3; r >= 0; r--) if (drv[r] != R) m_road = r;
            end
        end
    endtask

    function automatic logic [17:0] model_view();
        return {3'(m_safe[0]), 3'(m_safe[1]), 3'(m_safe[2]), 3'(m_safe[3]),
                (m_mode != 0), 3'(m_code), 2'(m_road)};
    endfunction

    function automatic logic [17:0] dut_view();
        return {bus_if.safe_M1, bus_if.safe_M2, bus_if.safe_MT, bus_if.safe_S,
                bus_if.fault, bus_if.fault_code, bus_if.fault_road};
    endfunction

    // Drive one set of controller outputs, clock it in and advance the model.
    task applyStimulus(input int m1, input int m2, input int mt, input int s, input bit clr);
        drv[0]  = m1;
        drv[1]  = m2;
        drv[2]  = mt;
        drv[3]  = s;
        drv_clr = clr;
        bus_if.light_M1  = 3'(m1);
        bus_if.light_M2  = 3'(m2);
        bus_if.light_MT  = 3'(mt);
        bus_if.light_S   = 3'(s);
        bus_if.fault_clr = clr;
        @(posedge clk);
        model_edge();
        cycle++;
        #1;
    endtask

    task do_reset();
        rst = 1'b0;
        drv_clr = 1'b0;
        for (int r = 0; r < 4; r++) drv[r] = R;
        bus_if.light_M1  = 3'b100;
        bus_if.light_M2  = 3'b100;
        bus_if.light_MT  = 3'b100;
        bus_if.light_S   = 3'b100;
        bus_if.fault_clr = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task test_reset();
        do_reset();
        rst = 1'b0;
        #2;
        checks++;
        if (dut_view() !== {12'b100_100_100_100, 1'b0, 3'd0, 2'd0}) begin
            errors++;
            $display("[TB] FAIL reset_values got=%h want=%h", dut_view(), {12'b100_100_100_100, 1'b0, 3'd0, 2'd0});
        end
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(R, R, R, R, 1'b1);
        checks++;
        if (dut_view() !== model_view()) begin
            errors++;
            $display("[TB] FAIL reset_clr_in_run got=%h want=%h", dut_view(), model_view());
        end
    endtask

    task test_normal_cycle();
        do_reset();
        for (int n = 0; n < 12; n++) begin
            if (n < 5)      applyStimulus(G, G, R, R, 1'b0);
            else if (n < 8) applyStimulus(Y, Y, R, R, 1'b0);
            else            applyStimulus(R, R, R, G, 1'b0);
            checks++;
            if (dut_view() !== model_view() || bus_if.fault !== 1'b0) begin
                errors++;
                $display("[TB] FAIL normal_cycle cyc=%0d got=%h want=%h", cycle, dut_view(), model_view());
            end
        end
    endtask

    task test_conflict();
        do_reset();
        applyStimulus(G, R, R, G, 1'b0);
        checks++;
        if (bus_if.fault !== 1'b1 || bus_if.fault_code !== 3'd2 || bus_if.fault_road !== 2'd3 ||
            bus_if.safe_S !== 3'b100) begin
            errors++;
            $display("[TB] FAIL conflict_latch got fault=%b code=%0d road=%0d safe_S=%b want fault=1 code=2 road=3 safe_S=100",
                     bus_if.fault, bus_if.fault_code, bus_if.fault_road, bus_if.safe_S);
        end
        for (int n = 0; n < 6; n++) begin
            applyStimulus(G, R, R, G, 1'b0);
            checks++;
            if (dut_view() !== model_view() || bus_if.safe_M1 !== ((n % 2 == 0) ? 3'b000 : 3'b100)) begin
                errors++;
                $display("[TB] FAIL conflict_flash cyc=%0d got=%h want=%h", cycle, dut_view(), model_view());
            end
        end
    endtask

    task test_short_yellow();
        do_reset();
        applyStimulus(G, R, R, R, 1'b0);
        applyStimulus(Y, R, R, R, 1'b0);
        applyStimulus(Y, R, R, R, 1'b0);
        checks++;
        if (dut_view() !== model_view() || bus_if.fault !== 1'b0) begin
            errors++;
            $display("[TB] FAIL short_yellow_pre got=%h want=%h", dut_view(), model_view());
        end
        applyStimulus(R, R, R, R, 1'b0);
        checks++;
        if (bus_if.fault !== 1'b1 || bus_if.fault_code !== 3'd4 || bus_if.fault_road !== 2'd0) begin
            errors++;
            $display("[TB] FAIL short_yellow got code=%0d road=%0d want code=4 road=0",
                     bus_if.fault_code, bus_if.fault_road);
        end
    endtask

    task test_skip_and_encoding();
        do_reset();
        applyStimulus(R, R, G, R, 1'b0);
        applyStimulus(R, R, R, R, 1'b0);
        checks++;
        if (bus_if.fault_code !== 3'd3 || bus_if.fault_road !== 2'd2 || dut_view() !== model_view()) begin
            errors++;
            $display("[TB] FAIL skip_yellow got code=%0d road=%0d want code=3 road=2",
                     bus_if.fault_code, bus_if.fault_road);
        end
        do_reset();
        applyStimulus(R, R, R, 3, 1'b0);
        checks++;
        if (bus_if.fault_code !== 3'd1 || bus_if.fault_road !== 2'd3 || dut_view() !== model_view()) begin
            errors++;
            $display("[TB] FAIL encoding_s got code=%0d road=%0d want code=1 road=3",
                     bus_if.fault_code, bus_if.fault_road);
        end
        do_reset();
        applyStimulus(0, R, R, 3, 1'b0);
        checks++;
        if (bus_if.fault_code !== 3'd1 || bus_if.fault_road !== 2'd0 || dut_view() !== model_view()) begin
            errors++;
            $display("[TB] FAIL encoding_two got code=%0d road=%0d want code=1 road=0",
                     bus_if.fault_code, bus_if.fault_road);
        end
    endtask

    task test_clear_recover();
        do_reset();
        applyStimulus(G, R, R, G, 1'b0);
        applyStimulus(R, R, R, R, 1'b0);
        applyStimulus(G, R, R, R, 1'b1);
        checks++;
        if (bus_if.fault !== 1'b1 || bus_if.fault_code !== 3'd2 || dut_view() !== model_view()) begin
            errors++;
            $display("[TB] FAIL clear_ignored got=%h want=%h", dut_view(), model_view());
        end
        applyStimulus(R, R, R, R, 1'b1);
        checks++;
        if (bus_if.fault !== 1'b1 || dut_view() !== model_view()) begin
            errors++;
            $display("[TB] FAIL recover_enter got=%h want=%h", dut_view(), model_view());
        end
        applyStimulus(R, R, R, R, 1'b0);
        checks++;
        if (bus_if.fault !== 1'b1 || bus_if.fault_code !== 3'd2) begin
            errors++;
            $display("[TB] FAIL recover_hold got fault=%b code=%0d want fault=1 code=2",
                     bus_if.fault, bus_if.fault_code);
        end
        applyStimulus(R, R, R, R, 1'b0);
        checks++;
        if (bus_if.fault !== 1'b0 || bus_if.fault_code !== 3'd0 || dut_view() !== model_view()) begin
            errors++;
            $display("[TB] FAIL recover_done got fault=%b code=%0d want fault=0 code=0",
                     bus_if.fault, bus_if.fault_code);
        end
        applyStimulus(G, R, R, R, 1'b0);
        applyStimulus(R, R, R, R, 1'b0);
        applyStimulus(R, R, R, R, 1'b1);
        applyStimulus(R, G, R, R, 1'b0);
        checks++;
        if (bus_if.fault !== 1'b1 || bus_if.fault_code !== 3'd3 || bus_if.fault_road !== 2'd1 ||
            dut_view() !== model_view()) begin
            errors++;
            $display("[TB] FAIL recover_abort got code=%0d road=%0d want code=3 road=1",
                     bus_if.fault_code, bus_if.fault_road);
        end
    endtask

    task test_reset_mid_fault();
        do_reset();
        applyStimulus(R, G, G, R, 1'b0);
        applyStimulus(R, G, G, R, 1'b0);
        checks++;
        if (dut_view() !== model_view()) begin
            errors++;
            $display("[TB] FAIL mid_fault_pre got=%h want=%h", dut_view(), model_view());
        end
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        checks++;
        if (dut_view() !== model_view() || bus_if.fault !== 1'b0 || bus_if.safe_MT !== 3'b100) begin
            errors++;
            $display("[TB] FAIL mid_fault_reset got=%h want=%h", dut_view(), model_view());
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task test_random();
        int v [4];
        int p;
        bit clr;
        do_reset();
        for (int r = 0; r < 4; r++) v[r] = R;
        for (int n = 0; n < 800; n++) begin
            for (int r = 0; r < 4; r++) begin
                p = int'($urandom_range(0, 99));
                if (p < 10) begin
                    v[r] = (v[r] == R) ? G : (v[r] == G) ? Y : R;
                end else if (p < 12) begin
                    case ($urandom_range(0, 2))
                        0:       v[r] = R;
                        1:       v[r] = Y;
                        default: v[r] = G;
                    endcase
                end else if (p == 12) begin
                    v[r] = int'($urandom_range(0, 7));
                end
            end
            if (m_mode != 0 && $urandom_range(0, 2) != 0) begin
                for (int r = 0; r < 4; r++) v[r] = R;
            end
            clr = ($urandom_range(0, 3) == 0);
            applyStimulus(v[0], v[1], v[2], v[3], clr);
            checks++;
            if (dut_view() !== model_view()) begin
                errors++;
                $display("[TB] FAIL random cyc=%0d got=%h want=%h", cycle, dut_view(), model_view());
            end
        end
    endtask

    initial begin
        test_reset();
        test_normal_cycle();
        test_conflict();
        test_short_yellow();
        test_skip_and_encoding();
        test_clear_recover();
        test_reset_mid_fault();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
